gpio_serial_rx: RTL and testbench
=================================

// Module: gpio_serial_rx
// PURPOSE
// - Upstream feeder for the AHB GPIO peripheral: deserialises a UART-style frame on one external pin.
// - Presents each word as a 17-bit {parity, data[15:0]} bus in GPIOIN format.
// - Received parity is passed through unchecked; the GPIO peripheral's PARITYSEL logic judges it.
// - RXWORD is held stable between frames, so the GPIO input path (dir = 0) samples a steady value.
// PARAMETERS
// - CLKS_PER_BIT  16  HCLK cycles per serial bit; even, >= 4
// - DATA_W        16  data bits per frame; fixed at 16 to match GPIOIN[15:0]
// PORTS
// - HCLK      in   1   system clock; single clock domain
// - HRESETn   in   1   asynchronous, active-low reset
// - RXD       in   1   asynchronous serial input; idle high
// - RXWORD    out  17  last good frame {parity, data}; connects to AHBGPIO GPIOIN
// - RXVALID   out  1   one-cycle pulse: RXWORD updated this cycle
// - FRAMEERR  out  1   one-cycle pulse: stop bit sampled low, frame discarded
// - BUSY      out  1   high from start-bit detect until return to IDLE
// BEHAVIOUR
// - Reset values (async assert, sync release on HCLK):
//   - RXWORD = 17'h0, which is a valid even-parity word; RXVALID, FRAMEERR, BUSY = 0.
//   - State = IDLE; both sync flops = 1.
// - Input path:
//   - RXD passes through a 2-flop synchroniser (rxd_s).
//   - Falling-edge detect on rxd_s (prev 1, now 0) is active only in IDLE.
// - Frame, LSB first: start(0), d0..d15, parity, stop(1) = 19 bits.
// - FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
//   - IDLE -> START on falling edge; load bit counter with CLKS_PER_BIT/2-1; BUSY rises the next cycle.
//   - START: at count 0, sample rxd_s.
//     - 0 -> DATA, reload counter to CLKS_PER_BIT-1.
//     - 1 -> IDLE (glitch rejected); no output pulse.
//   - DATA: at each count 0, shift rxd_s into shift_reg MSB, shifting right.
//     - After 16 samples -> PARITY; data index counter 0..15.
//   - PARITY: at count 0, capture rxd_s into par_bit -> STOP.
//   - STOP: at count 0, sample rxd_s.
//     - 1 -> RXWORD <= {par_bit, shift_reg}; RXVALID = 1 on the next cycle; go to IDLE.
//     - 0 -> FRAMEERR = 1 on the next cycle; RXWORD unchanged; go to WAIT_HIGH.
//   - WAIT_HIGH -> IDLE when rxd_s = 1. A held-low break therefore cannot retrigger.
// - Timing:
//   - Each sample is taken at mid-bit.
//   - Stop sampled 18*CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after edge detect.
//   - RXVALID follows one cycle later. Add 2 cycles of synchroniser delay from the RXD pin.
// - RXWORD changes only in the RXVALID cycle; it is never partially updated.
// - Back-to-back frames:
//   - A new start edge is accepted from the cycle after RXVALID.
//   - A falling edge during the stop-bit tail is caught once the FSM is in IDLE.
// - Counters:
//   - Bit counter is $clog2(CLKS_PER_BIT) bits and is a down-counter; no wrap is needed.
//   - Index counter is 5 bits.
// - Reset mid-frame: all state is cleared immediately and the partial frame is lost; no pulse is emitted.
// - RXVALID and FRAMEERR are never high in the same cycle.
// STRUCTURE
// - gpio_pkg:
//   - rx_state_t enum;
//   - FRAME_BITS = 19;
//   - GPIO_W = 17.
// - Sub-module gpio_sync2: 2-flop synchroniser, reset value 1, reusable for other GPIO pins.
// - Top level holds the FSM, bit/index counters, shift_reg[15:0], par_bit, and output registers.
// TESTING (CLKS_PER_BIT=16 unless noted)
// - Reset:
//   - Stimulus: assert HRESETn low mid-frame (after 5 data bits), release, send a clean frame.
//   - Required: RXWORD = 0, no pulses while in reset; the next full frame decodes correctly.
// - Good frame:
//   - Stimulus: data 16'hA5C3 with even parity bit 0, stop 1.
//   - Required: RXWORD = 17'h0A5C3; exactly one RXVALID pulse, 2+18*16+8+1 cycles after the RXD fall.
// - Bad parity passthrough:
//   - Stimulus: data 16'h0001 with parity bit 0.
//   - Required: RXWORD = 17'h00001 and RXVALID pulses. With AHBGPIO dir = 0 and PARITYSEL = 0, PARITYERR goes to 1.
// - Framing error:
//   - Stimulus: data 16'hFFFF, parity 0, stop 0, then RXD held low for 40 bit times.
//   - Required: one FRAMEERR pulse; RXWORD keeps its previous value; BUSY stays high; no retrigger until RXD returns high.
// - Glitch rejection:
//   - Stimulus: RXD low for 6 cycles, then high.
//   - Required: FSM returns to IDLE; no RXVALID or FRAMEERR.
// - Back-to-back:
//   - Stimulus: frames 16'h1234 and 16'hFEDC with no idle gap; repeat with CLKS_PER_BIT = 4.
//   - Required: two RXVALID pulses, values in order, no FRAMEERR.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared types and widths for the GPIO serial receive path.
package gpio_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;
    localparam int FRAME_BITS = 19;
    localparam int GPIO_W = 17;
    localparam int DATA_W = GPIO_W - 1;
endpackage

// File: rtl/gpio_sync2.sv
// gpio_sync2: two-flop synchroniser for an asynchronous GPIO pin, resets to idle-high.
module gpio_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
endmodule

// File: rtl/gpio_serial_rx.sv
// gpio_serial_rx: UART-style 16-bit frame deserialiser feeding GPIOIN as {parity, data}.
module gpio_serial_rx
    import gpio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              RXD,
    output logic [GPIO_W-1:0] RXWORD,
    output logic              RXVALID,
    output logic              FRAMEERR,
    output logic              BUSY
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic              rxd_s, rxd_prev_q, tick;
    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [GPIO_W-1:0] word_q, word_d;
    logic              valid_q, valid_d, err_q, err_d, busy_q;

    gpio_sync2 u_sync (.clk(HCLK), .rst_n(HRESETn), .d(RXD), .q(rxd_s));

    assign tick = cnt_q == '0;

    // Every sampling state reloads a full bit period on its sample tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? FULL : cnt_q - 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        word_d  = word_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = HALF;
                idx_d = '0;
                if (rxd_prev_q && !rxd_s) state_d = START;
            end
            START: if (tick) state_d = rxd_s ? IDLE : DATA;
            DATA: if (tick) begin
                shift_d = {rxd_s, shift_q[DATA_W-1:1]};
                idx_d   = idx_q + 5'd1;
                if (idx_q == 5'(DATA_W - 1)) state_d = PARITY;
            end
            PARITY: if (tick) begin
                par_d   = rxd_s;
                state_d = STOP;
            end
            STOP: if (tick) begin
                state_d = rxd_s ? IDLE : WAIT_HIGH;
                valid_d = rxd_s;
                err_d   = !rxd_s;
                word_d  = rxd_s ? {par_q, shift_q} : word_q;
            end
            WAIT_HIGH: if (rxd_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rxd_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= state_d != IDLE;
            rxd_prev_q <= rxd_s;
        end
    end

    assign RXWORD   = word_q;
    assign RXVALID  = valid_q;
    assign FRAMEERR = err_q;
    assign BUSY     = busy_q;
endmodule

// File: tb/tb_gpio_serial_rx.sv
// tb_gpio_serial_rx: directed and random frames into 16- and 4-clock-per-bit receivers.
module tb_gpio_serial_rx;
    logic        clk = 1'b0, rst_n = 1'b0, rxd_a = 1'b1, rxd_b = 1'b1;
    logic [16:0] word_a, word_b, prev_a = '0, prev_b = '0, last_a, last_b;
    logic        val_a, val_b, err_a, err_b, busy_a, busy_b, rst_prev = 1'b0;
    logic [15:0] d;
    logic        p;
    int          vectors = 0, miscompares = 0, cyc = 0;
    int          fall_a, fall_b, vcyc_a, vcyc_b, nerr_a = 0, nerr_b = 0, ne;
    logic [16:0] got_a[$], got_b[$], exp_a[$], exp_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpio_serial_rx #(.CLKS_PER_BIT(16)) dut_a (.HCLK(clk), .HRESETn(rst_n), .RXD(rxd_a),
        .RXWORD(word_a), .RXVALID(val_a), .FRAMEERR(err_a), .BUSY(busy_a));
    gpio_serial_rx #(.CLKS_PER_BIT(4)) dut_b (.HCLK(clk), .HRESETn(rst_n), .RXD(rxd_b),
        .RXWORD(word_b), .RXVALID(val_b), .FRAMEERR(err_b), .BUSY(busy_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outside reset RXWORD may only move in an RXVALID cycle; the two pulses are exclusive.
    always @(negedge clk) begin
        if (rst_n && rst_prev) begin
            if (!val_a) chk("hold_a", 32'(word_a), 32'(prev_a));
            if (!val_b) chk("hold_b", 32'(word_b), 32'(prev_b));
        end
        if (val_a || err_a) chk("excl_a", 32'(val_a & err_a), 32'd0);
        if (val_b || err_b) chk("excl_b", 32'(val_b & err_b), 32'd0);
        if (val_a) begin got_a.push_back(word_a); vcyc_a <= cyc; end
        if (val_b) begin got_b.push_back(word_b); vcyc_b <= cyc; end
        if (err_a) nerr_a <= nerr_a + 1;
        if (err_b) nerr_b <= nerr_b + 1;
        prev_a   <= word_a;
        prev_b   <= word_b;
        rst_prev <= rst_n;
    end

    // Drives the first nbits of a frame {stop, parity, data, start} LSB first.
    task automatic send(input bit b, input logic [15:0] dat, input bit par, input bit stop,
                        input int nbits = 19);
        int cpb = b ? 4 : 16;
        logic [18:0] f = {stop, par, dat, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (b) rxd_b = f[i]; else rxd_a = f[i];
            if (i == 0 && b) fall_b = cyc;
            if (i == 0 && !b) fall_a = cyc;
            repeat (cpb) @(negedge clk);
        end
        if (stop && nbits == 19) begin
            if (b) exp_b.push_back({par, dat}); else exp_a.push_back({par, dat});
        end
    endtask

    task automatic check_q();
        repeat (10) @(negedge clk);
        chk("count_a", got_a.size(), exp_a.size());
        chk("count_b", got_b.size(), exp_b.size());
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
            chk($sformatf("word_a[%0d]", i), 32'(got_a[i]), 32'(exp_a[i]));
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
            chk($sformatf("word_b[%0d]", i), 32'(got_b[i]), 32'(exp_b[i]));
        if (exp_a.size() > 0) last_a = exp_a[exp_a.size() - 1];
        if (exp_b.size() > 0) last_b = exp_b[exp_b.size() - 1];
        got_a.delete(); exp_a.delete(); got_b.delete(); exp_b.delete();
    endtask

    initial begin
        last_a = '0;
        last_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_word_a", 32'(word_a), 32'd0);
        chk("rst_word_b", 32'(word_b), 32'd0);
        chk("rst_pulses", 32'({val_a, err_a, busy_a, val_b, err_b, busy_b}), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);

        send(0, 16'hA5C3, 1'b0, 1'b1);
        check_q();
        chk("good_word", 32'(word_a), 32'h0A5C3);
        chk("good_latency", vcyc_a - fall_a, 2 + 18 * 16 + 8 + 1);
        chk("good_busy_low", 32'(busy_a), 32'd0);

        send(0, 16'h0001, 1'b0, 1'b1);
        check_q();
        chk("badpar_word", 32'(word_a), 32'h00001);
        chk("badpar_parityerr", 32'(^word_a), 32'd1);

        ne = got_a.size();
        send(0, 16'hBEEF, 1'b1, 1'b1, 6);
        chk("mid_busy", 32'(busy_a), 32'd1);
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_word", 32'(word_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_nopulse", got_a.size(), ne);
        rxd_a = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_after_word", 32'(word_a), 32'd0);
        send(0, 16'h5A3C, 1'b1, 1'b1);
        check_q();
        chk("mid_clean_word", 32'(word_a), 32'h15A3C);

        for (int k = 0; k < 4; k++) begin
            d = 16'($urandom);
            p = 1'($urandom);
            send(0, d, p, 1'b1);
        end
        check_q();
        chk("rand_last_a", 32'(word_a), 32'(last_a));

        ne = nerr_a;
        send(0, 16'hFFFF, 1'b0, 1'b0);
        repeat (40 * 16) @(negedge clk);
        chk("ferr_count", nerr_a - ne, 1);
        chk("ferr_word_kept", 32'(word_a), 32'(last_a));
        chk("ferr_busy_high", 32'(busy_a), 32'd1);
        chk("ferr_no_valid", got_a.size(), 0);
        rxd_a = 1'b1;
        repeat (10) @(negedge clk);
        chk("ferr_busy_released", 32'(busy_a), 32'd0);
        chk("ferr_no_retrigger", nerr_a - ne, 1);

        rxd_a = 1'b0;
        repeat (6) @(negedge clk);
        rxd_a = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_busy", 32'(busy_a), 32'd0);
        chk("glitch_no_valid", got_a.size(), 0);
        chk("glitch_no_ferr", nerr_a - ne, 1);

        send(0, 16'h1234, 1'b1, 1'b1);
        send(0, 16'hFEDC, 1'b0, 1'b1);
        check_q();

        d = 16'($urandom);
        send(1, d, ^d, 1'b1);
        check_q();
        chk("b_latency", vcyc_b - fall_b, 2 + 18 * 4 + 2 + 1);
        send(1, 16'h1234, 1'b1, 1'b1);
        send(1, 16'hFEDC, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            d = 16'($urandom);
            p = 1'($urandom);
            send(1, d, p, 1'b1);
        end
        check_q();
        chk("b_last_word", 32'(word_b), 32'(last_b));
        chk("b_no_ferr", nerr_b, 0);
        chk("a_ferr_total", nerr_a, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
